// File: rtl/wb_regfile_pkg.sv
// Shared widths, types and constants for the write-back register file.
package wb_regfile_pkg;

  localparam int unsigned DSize   = 32;
  localparam int unsigned ASize   = 5;
  localparam int unsigned NumRegs = 2 ** ASize;

  typedef logic [DSize-1:0] data_t;
  typedef logic [ASize-1:0] addr_t;

  localparam addr_t RegZero = '0;

endpackage

// File: rtl/wb_regfile_if.sv
// Write-back commit port plus the two decode-stage read ports.
interface wb_regfile_if;
  import wb_regfile_pkg::*;

  logic  wen;
  addr_t waddr;
  data_t wdata;
  addr_t raddr1;
  addr_t raddr2;
  data_t rdata1;
  data_t rdata2;

  modport master (
    output wen, waddr, wdata, raddr1, raddr2,
    input  rdata1, rdata2
  );

  modport slave (
    input  wen, waddr, wdata, raddr1, raddr2,
    output rdata1, rdata2
  );

endinterface

// File: rtl/wb_regfile_rdport.sv
// One combinational read port: r0 check, same-cycle WB bypass, array mux.
module wb_regfile_rdport
  import wb_regfile_pkg::*;
(
  input  logic  rst_ni,
  input  addr_t raddr_i,
  input  logic  wen_i,
  input  addr_t waddr_i,
  input  data_t wdata_i,
  input  data_t mem_i [NumRegs],
  output data_t rdata_o
);

  // Reset dominates the bypass; r0 never bypasses.
  always_comb begin
    rdata_o = '0;
    if (raddr_i == RegZero) begin
      rdata_o = '0;
    end else if (rst_ni && wen_i && (waddr_i == raddr_i)) begin
      rdata_o = wdata_i;
    end else if (rst_ni) begin
      rdata_o = mem_i[raddr_i];
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Architectural register file: posedge commit from WB, two bypassed read ports.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input logic         clk_i,
  input logic         rst_ni,
  wb_regfile_if.slave bus
);

  data_t mem_q [NumRegs];

  // Entry 0 is cleared on reset and never written, so it stays 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumRegs; i++) begin
        mem_q[i] <= '0;
      end
    end else if (bus.wen && (bus.waddr != RegZero)) begin
      mem_q[bus.waddr] <= bus.wdata;
    end
  end

  wb_regfile_rdport u_rdport1 (
    .rst_ni  (rst_ni),
    .raddr_i (bus.raddr1),
    .wen_i   (bus.wen),
    .waddr_i (bus.waddr),
    .wdata_i (bus.wdata),
    .mem_i   (mem_q),
    .rdata_o (bus.rdata1)
  );

  wb_regfile_rdport u_rdport2 (
    .rst_ni  (rst_ni),
    .raddr_i (bus.raddr2),
    .wen_i   (bus.wen),
    .waddr_i (bus.waddr),
    .wdata_i (bus.wdata),
    .mem_i   (mem_q),
    .rdata_o (bus.rdata2)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile with a per-cycle reference-model check.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  logic [31:0] model [32];

  wb_regfile_if bus_if ();

  wb_regfile u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: what the array must hold after each committed write.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model[i] <= 32'h0;
    end else if (bus_if.wen && bus_if.waddr != 5'd0) begin
      model[bus_if.waddr] <= bus_if.wdata;
    end
  end

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (!rst_n) return 32'h0;
    if (bus_if.wen && bus_if.waddr == a) return bus_if.wdata;
    return model[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison on the falling edge, away from the commit edge.
  always @(negedge clk) begin
    check("model_rd1", bus_if.rdata1, exp_read(bus_if.raddr1));
    check("model_rd2", bus_if.rdata2, exp_read(bus_if.raddr2));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus_if.wen   = 1'b1;
    bus_if.waddr = a;
    bus_if.wdata = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus_if.wen    = 1'b0;
    bus_if.waddr  = '0;
    bus_if.wdata  = '0;
    bus_if.raddr1 = 5'd5;
    bus_if.raddr2 = 5'd31;
    step();
    step();
    check("reset_rd1", bus_if.rdata1, 32'h0);
    check("reset_rd2", bus_if.rdata2, 32'h0);
    rst_n = 1'b1;
    step();

    // Bypass in the write cycle, then the committed value from the array.
    wr(5'd3, 32'h1234_5678);
    bus_if.raddr1 = 5'd3;
    #1 check("bypass_r3", bus_if.rdata1, 32'h1234_5678);
    step();
    bus_if.wen = 1'b0;
    #1 check("mem_r3", bus_if.rdata1, 32'h1234_5678);
    step();

    // r0 stays zero even when targeted by a write.
    wr(5'd0, 32'hFFFF_FFFF);
    bus_if.raddr1 = 5'd0;
    bus_if.raddr2 = 5'd0;
    #1 check("r0_during_rd1", bus_if.rdata1, 32'h0);
    check("r0_during_rd2", bus_if.rdata2, 32'h0);
    step();
    bus_if.wen = 1'b0;
    #1 check("r0_after_rd1", bus_if.rdata1, 32'h0);
    check("r0_after_rd2", bus_if.rdata2, 32'h0);
    step();

    // Both ports on one register, then an independent per-port bypass.
    wr(5'd7, 32'hA5A5_A5A5);
    step();
    bus_if.wen    = 1'b0;
    bus_if.raddr1 = 5'd7;
    bus_if.raddr2 = 5'd7;
    #1 check("r7_rd1", bus_if.rdata1, 32'hA5A5_A5A5);
    check("r7_rd2", bus_if.rdata2, 32'hA5A5_A5A5);
    step();
    wr(5'd7, 32'h0000_0001);
    bus_if.raddr1 = 5'd8;
    #1 check("r7_bypass_rd2", bus_if.rdata2, 32'h0000_0001);
    check("r8_untouched_rd1", bus_if.rdata1, 32'h0);
    step();
    bus_if.wen = 1'b0;
    #1 check("r7_new_rd2", bus_if.rdata2, 32'h0000_0001);

    // wen=0 must neither write nor bypass.
    wr(5'd9, 32'h0000_0077);
    step();
    bus_if.wen    = 1'b0;
    bus_if.waddr  = 5'd9;
    bus_if.wdata  = 32'h0000_BEEF;
    bus_if.raddr1 = 5'd9;
    for (int c = 0; c < 3; c++) begin
      #1 check("r9_no_wen", bus_if.rdata1, 32'h0000_0077);
      step();
    end

    // Asynchronous reset mid-cycle, writes blocked while held, clean release.
    wr(5'd5, 32'h0000_DEAD);
    step();
    bus_if.wen    = 1'b0;
    bus_if.raddr1 = 5'd5;
    bus_if.raddr2 = 5'd3;
    #1 check("r5_before_rst", bus_if.rdata1, 32'h0000_DEAD);
    #1 rst_n = 1'b0;
    #1 check("r5_async_rst", bus_if.rdata1, 32'h0);
    check("r3_async_rst", bus_if.rdata2, 32'h0);
    wr(5'd5, 32'h0000_1234);
    #1 check("r5_no_bypass_rst", bus_if.rdata1, 32'h0);
    step();
    bus_if.wen = 1'b0;
    #1 check("r5_no_write_rst", bus_if.rdata1, 32'h0);
    rst_n = 1'b1;
    wr(5'd4, 32'h0000_0044);
    step();
    bus_if.wen = 1'b0;
    #1 check("r5_after_release", bus_if.rdata1, 32'h0);
    bus_if.raddr1 = 5'd4;
    #1 check("r4_first_write", bus_if.rdata1, 32'h0000_0044);
    step();

    // Back-to-back fill r1..r31, then sweep both ports.
    for (int i = 1; i < 32; i++) begin
      wr(5'(i), 32'(i));
      step();
    end
    bus_if.wen = 1'b0;
    for (int a = 0; a < 32; a++) begin
      bus_if.raddr1 = 5'(a);
      bus_if.raddr2 = 5'(31 - a);
      #1 check("sweep_rd1", bus_if.rdata1, 32'(a));
      check("sweep_rd2", bus_if.rdata2, 32'(31 - a));
      check("sweep_model", bus_if.rdata1, model[a]);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
